// File: rtl/grey_sobel_edge.sv
// Streaming 3x3 Sobel edge detector: two line buffers, 3x3 window, saturated |Gx|+|Gy|, 3-cycle latency.
// Build option: define SOBEL_BINARY_EN to add i_thresh and emit a 0/255 binary edge map instead of magnitude.
module grey_sobel_edge #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_vsync,
    input  logic        i_de,
    input  logic [7:0]  i_grey8b,
`ifdef SOBEL_BINARY_EN
    input  logic [7:0]  i_thresh,
`endif
    output logic        o_de,
    output logic [7:0]  o_edge8b,
    output logic [15:0] o_edgedata
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_BORDER = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_BORDER = ROW_W'(2);

    // Weighted column/row sum a + 2b + c, zero-extended to 10 bits (max 1020).
    function automatic logic [9:0] tap_sum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // ------------------------------------------------------------------
    // Pixel coordinates
    // ------------------------------------------------------------------
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] pix_col;
    logic [ROW_W-1:0] pix_row;

    // A pixel arriving together with i_vsync is (0,0) of the new frame.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        pix_col = i_vsync ? '0 : col;
        pix_row = i_vsync ? '0 : row;
    end

    // NOTE: sequential state is updated only with non-blocking assignments so all
    // registers sample the same pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            col <= '0;
            row <= '0;
        end else if (i_de) begin
            if (pix_col == COL_LAST) begin
                col <= '0;
                row <= (pix_row == ROW_LAST) ? '0 : pix_row + 1'b1;
            end else begin
                col <= pix_col + 1'b1;
                row <= pix_row;
            end
        end else if (i_vsync) begin
            col <= '0;
            row <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: lb0 holds row-1, lb1 holds row-2 at each column
    // ------------------------------------------------------------------
    logic [7:0] lb0_mem [IMG_W];
    logic [7:0] lb1_mem [IMG_W];
    logic [7:0] lb0_rd;
    logic [7:0] lb1_rd;

    assign lb0_rd = lb0_mem[pix_col];
    assign lb1_rd = lb1_mem[pix_col];

    // NOTE: the line-buffer RAM is deliberately not reset; stale rows are only ever
    // seen by border pixels, whose output is forced to zero.
    always_ff @(posedge i_clk) begin
        if (i_de) begin
            lb0_mem[pix_col] <= i_grey8b;
            lb1_mem[pix_col] <= lb0_rd;
        end
    end

    // ------------------------------------------------------------------
    // S1: 3x3 window (win[row][col], row 0 = top, col 0 = left) and border flag
    // ------------------------------------------------------------------
    logic [7:0] win [3][3];
    logic       s1_valid;
    logic       s1_border;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
            s1_valid  <= 1'b0;
            s1_border <= 1'b0;
        end else begin
            s1_valid <= i_de;
            if (i_de) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb1_rd;
                win[1][2] <= lb0_rd;
                win[2][2] <= i_grey8b;
                s1_border <= (pix_row < ROW_BORDER) || (pix_col < COL_BORDER);
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: gradients, two's-complement 11-bit (-1020..1020)
    // ------------------------------------------------------------------
    logic [9:0]  gx_pos, gx_neg, gy_pos, gy_neg;
    logic [10:0] gx_c, gy_c;
    logic [10:0] s2_gx, s2_gy;
    logic        s2_valid;
    logic        s2_border;

    always_comb begin
        gx_pos = tap_sum(win[0][2], win[1][2], win[2][2]);
        gx_neg = tap_sum(win[0][0], win[1][0], win[2][0]);
        gy_pos = tap_sum(win[2][0], win[2][1], win[2][2]);
        gy_neg = tap_sum(win[0][0], win[0][1], win[0][2]);
        gx_c   = {1'b0, gx_pos} - {1'b0, gx_neg};
        gy_c   = {1'b0, gy_pos} - {1'b0, gy_neg};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s2_gx     <= '0;
            s2_gy     <= '0;
            s2_valid  <= 1'b0;
            s2_border <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_gx     <= gx_c;
                s2_gy     <= gy_c;
                s2_border <= s1_border;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: |Gx|+|Gy| (max 2040 fits 11 bits), saturate, border mask, output
    // ------------------------------------------------------------------
    logic [10:0] gx_abs, gy_abs, mag;
    logic [7:0]  mag_sat;
    logic [7:0]  edge_val;

    always_comb begin
        gx_abs   = s2_gx[10] ? (~s2_gx + 11'd1) : s2_gx;
        gy_abs   = s2_gy[10] ? (~s2_gy + 11'd1) : s2_gy;
        mag      = gx_abs + gy_abs;
        mag_sat  = (mag > 11'd255) ? 8'hFF : mag[7:0];
        edge_val = 8'h00;
        if (!s2_border) begin
`ifdef SOBEL_BINARY_EN
            edge_val = (mag_sat >= i_thresh) ? 8'hFF : 8'h00;
`else
            edge_val = mag_sat;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_de       <= 1'b0;
            o_edge8b   <= '0;
            o_edgedata <= '0;
        end else begin
            o_de <= s2_valid;
            if (s2_valid) begin
                o_edge8b   <= edge_val;
                o_edgedata <= {edge_val[7:3], edge_val[7:2], edge_val[7:3]};
            end
        end
    end

endmodule
